reaction_session_ctrl: RTL and testbench

- Session sequencer for the reaction-timer datapath. Runs TRIALS back-to-back reaction trials.
- Per trial: generates a pseudo-random foreperiod, lights the stimulus, then measures the response in milliseconds.
- Across the session: tracks the last, best and average times, and flags cheats and timeouts.
- Sits between the debounced button inputs, the 1 ms prescaler strobe and the BCD/seven-segment display path. All times are output in binary; BCD conversion happens downstream.

---
 rtl/reaction_session_ctrl.sv | 205 ++++++++++++++++++++
 tb/tb_reaction_session_ctrl.sv | 157 +++++++++++++++
 2 files changed

// File: rtl/reaction_session_ctrl.sv
// rtl/reaction_session_ctrl.sv - reaction-timer session sequencer
// Runs TRIALS reaction trials and tracks last, best and average response times.
module reaction_session_ctrl #(
  parameter int TRIALS      = 4,
  parameter int MIN_WAIT_MS = 1000,
  parameter int RAND_BITS   = 11,
  parameter int TIMEOUT_MS  = 1000,
  parameter int GAP_MS      = 500
) (
  input  logic                       clk,
  input  logic                       rst,
  input  logic                       ms_tick,
  input  logic                       start,
  input  logic                       react,
  input  logic                       abort,
  output logic                       led_on,
  output logic [2:0]                 state_o,
  output logic [$clog2(TRIALS)-1:0]  trial_idx,
  output logic [9:0]                 cur_ms,
  output logic [9:0]                 last_ms,
  output logic [9:0]                 best_ms,
  output logic [9:0]                 avg_ms,
  output logic                       done,
  output logic                       cheat,
  output logic                       timeout
);

  localparam int LOG2T   = $clog2(TRIALS);
  localparam int TIW     = LOG2T;
  localparam int SUM_W   = 10 + LOG2T;
  localparam int ARM_MAX = MIN_WAIT_MS + (1 << RAND_BITS) - 1;
  localparam int CNT_MAX = (ARM_MAX > GAP_MS) ? ARM_MAX : GAP_MS;
  localparam int CNT_W   = $clog2(CNT_MAX + 1);

  typedef enum logic [2:0] {
    S_IDLE   = 3'd0,
    S_ARM    = 3'd1,
    S_REACT  = 3'd2,
    S_RECORD = 3'd3,
    S_GAP    = 3'd4,
    S_DONE   = 3'd5,
    S_CHEAT  = 3'd6
  } state_t;

  state_t             state_q, state_d;
  logic [15:0]        lfsr_q, lfsr_d;
  logic [TIW-1:0]     trial_q, trial_d;
  logic [9:0]         cur_q, cur_d;
  logic [9:0]         last_q, last_d;
  logic [9:0]         best_q, best_d;
  logic [9:0]         avg_q, avg_d;
  logic [9:0]         rec_q, rec_d;
  logic [SUM_W-1:0]   sum_q, sum_d;
  logic [CNT_W-1:0]   cnt_q, cnt_d;
  logic [CNT_W-1:0]   wait_target_q, wait_target_d;
  logic               done_q, done_d;
  logic               cheat_q, cheat_d;
  logic               timeout_q, timeout_d;
  logic               new_session;
  logic [CNT_W-1:0]   cnt_inc;

  assign cnt_inc = cnt_q + CNT_W'(1);

  always_comb begin
    state_d       = state_q;
    lfsr_d        = {lfsr_q[14:0], lfsr_q[15] ^ lfsr_q[13] ^ lfsr_q[12] ^ lfsr_q[10]};
    trial_d       = trial_q;
    cur_d         = cur_q;
    last_d        = last_q;
    best_d        = best_q;
    avg_d         = avg_q;
    rec_d         = rec_q;
    sum_d         = sum_q;
    cnt_d         = cnt_q;
    wait_target_d = wait_target_q;
    done_d        = done_q;
    cheat_d       = cheat_q;
    timeout_d     = timeout_q;
    new_session   = 1'b0;

    if (abort) begin
      state_d = S_IDLE;
      cur_d   = '0;
      done_d  = 1'b0;
      cheat_d = 1'b0;
    end else begin
      case (state_q)
        S_IDLE, S_DONE, S_CHEAT: begin
          if (start) begin
            state_d     = S_ARM;
            new_session = 1'b1;
          end
        end
        S_ARM: begin
          if (react) begin
            state_d = S_CHEAT;
            cheat_d = 1'b1;
          end else if (ms_tick) begin
            cnt_d = cnt_inc;
            if (cnt_inc == wait_target_q) begin
              state_d = S_REACT;
              cur_d   = '0;
            end
          end
        end
        S_REACT: begin
          // A press on a tick edge records the count before that tick.
          if (react) begin
            rec_d   = cur_q;
            state_d = S_RECORD;
          end else if (ms_tick) begin
            cur_d = cur_q + 10'd1;
            if (cur_q == 10'(TIMEOUT_MS - 1)) begin
              rec_d     = 10'(TIMEOUT_MS);
              timeout_d = 1'b1;
              state_d   = S_RECORD;
            end
          end
        end
        S_RECORD: begin
          last_d = rec_q;
          sum_d  = sum_q + SUM_W'(rec_q);
          if (rec_q < best_q) best_d = rec_q;
          if (trial_q == TIW'(TRIALS - 1)) begin
            state_d = S_DONE;
            done_d  = 1'b1;
            avg_d   = 10'(sum_d >> LOG2T);
          end else begin
            trial_d = trial_q + TIW'(1);
            cnt_d   = '0;
            state_d = S_GAP;
          end
        end
        S_GAP: begin
          if (ms_tick) begin
            cnt_d = cnt_inc;
            if (cnt_inc == CNT_W'(GAP_MS)) state_d = S_ARM;
          end
        end
        default: state_d = S_IDLE;
      endcase
    end

    if (new_session) begin
      trial_d   = '0;
      sum_d     = '0;
      done_d    = 1'b0;
      cheat_d   = 1'b0;
      timeout_d = 1'b0;
      best_d    = 10'd1023;
    end

    // Each ARM entry draws a fresh foreperiod from the free-running LFSR.
    if (state_d == S_ARM && state_q != S_ARM) begin
      wait_target_d = CNT_W'(MIN_WAIT_MS) + CNT_W'(lfsr_q[RAND_BITS-1:0]);
      cnt_d         = '0;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q       <= S_IDLE;
      lfsr_q        <= 16'hACE1;
      trial_q       <= '0;
      cur_q         <= '0;
      last_q        <= '0;
      best_q        <= 10'd1023;
      avg_q         <= '0;
      rec_q         <= '0;
      sum_q         <= '0;
      cnt_q         <= '0;
      wait_target_q <= '0;
      done_q        <= 1'b0;
      cheat_q       <= 1'b0;
      timeout_q     <= 1'b0;
    end else begin
      state_q       <= state_d;
      lfsr_q        <= lfsr_d;
      trial_q       <= trial_d;
      cur_q         <= cur_d;
      last_q        <= last_d;
      best_q        <= best_d;
      avg_q         <= avg_d;
      rec_q         <= rec_d;
      sum_q         <= sum_d;
      cnt_q         <= cnt_d;
      wait_target_q <= wait_target_d;
      done_q        <= done_d;
      cheat_q       <= cheat_d;
      timeout_q     <= timeout_d;
    end
  end

  assign led_on    = (state_q == S_REACT);
  assign state_o   = state_q;
  assign trial_idx = trial_q;
  assign cur_ms    = cur_q;
  assign last_ms   = last_q;
  assign best_ms   = best_q;
  assign avg_ms    = avg_q;
  assign done      = done_q;
  assign cheat     = cheat_q;
  assign timeout   = timeout_q;

endmodule

// File: tb/tb_reaction_session_ctrl.sv
// tb/tb_reaction_session_ctrl.sv - table-driven bench for reaction_session_ctrl
module tb_reaction_session_ctrl;

  logic       clk = 1'b0;
  logic       rst, ms_tick, start, react, abort;
  logic       led_on;
  logic [2:0] state_o;
  logic [1:0] trial_idx;
  logic [9:0] cur_ms, last_ms, best_ms, avg_ms;
  logic       done, cheat, timeout;

  reaction_session_ctrl dut (
    .clk(clk), .rst(rst), .ms_tick(ms_tick), .start(start), .react(react), .abort(abort),
    .led_on(led_on), .state_o(state_o), .trial_idx(trial_idx), .cur_ms(cur_ms),
    .last_ms(last_ms), .best_ms(best_ms), .avg_ms(avg_ms), .done(done),
    .cheat(cheat), .timeout(timeout)
  );

  always #5 clk = ~clk;

  // Reference LFSR used to predict each foreperiod.
  logic [15:0] m;
  always @(posedge clk) begin
    if (rst) m <= 16'hACE1;
    else     m <= {m[14:0], m[15] ^ m[13] ^ m[12] ^ m[10]};
  end

  typedef struct {
    int kind; int n;
    bit t; bit r; bit s; bit a;
    int st; int tidx; int cur; int last; int best; int avg; int dn; int ch; int tmo;
  } vec_t;

  localparam int C = 0;
  localparam int W = 1;

  vec_t        vecs[$];
  int          passed = 0;
  int          total  = 0;
  int          row    = 0;
  logic [15:0] arm_seed = 16'h0;

  function automatic void add(int kind, int n, bit t, bit r, bit s, bit a,
                              int st, int tidx, int cur, int last, int best,
                              int avg, int dn, int ch, int tmo);
    vec_t v;
    v = '{kind, n, t, r, s, a, st, tidx, cur, last, best, avg, dn, ch, tmo};
    vecs.push_back(v);
  endfunction

  task automatic chk(input string name, input int act, input int exp);
    total++;
    if (act == exp) passed++;
    else $display("FAIL row %0d %s: got %0d expected %0d", row, name, act, exp);
  endtask

  task automatic cyc(input bit t, input bit r, input bit s, input bit a);
    logic [2:0]  prev;
    logic [15:0] seed;
    prev = state_o;
    seed = m;
    ms_tick = t; react = r; start = s; abort = a;
    @(negedge clk);
    ms_tick = 0; react = 0; start = 0; abort = 0;
    if (state_o == 3'd1 && prev != 3'd1) arm_seed = seed;
  endtask

  task automatic wait_react();
    int n;
    n = 0;
    while (led_on !== 1'b1 && n < 4000) begin
      cyc(1, 0, 0, 0);
      n++;
    end
    chk("arm_ticks", n, 1000 + int'(arm_seed[10:0]));
  endtask

  task automatic check_row(input vec_t v);
    chk("state_o",   int'(state_o),   v.st);
    chk("led_on",    int'(led_on),    int'(v.st == 2));
    chk("trial_idx", int'(trial_idx), v.tidx);
    chk("cur_ms",    int'(cur_ms),    v.cur);
    chk("last_ms",   int'(last_ms),   v.last);
    chk("best_ms",   int'(best_ms),   v.best);
    chk("avg_ms",    int'(avg_ms),    v.avg);
    chk("done",      int'(done),      v.dn);
    chk("cheat",     int'(cheat),     v.ch);
    chk("timeout",   int'(timeout),   v.tmo);
  endtask

  initial begin
    rst = 1; ms_tick = 0; start = 0; react = 0; abort = 0;
    repeat (2) @(negedge clk);
    rst = 0;

    //  kind n    t r s a  st tidx cur  last best avg dn ch tmo
    add(C, 0,    0,0,0,0, 0, 0,   0,   0,   1023, 0,  0, 0, 0);
    add(C, 100,  0,1,0,0, 0, 0,   0,   0,   1023, 0,  0, 0, 0);
    add(C, 1,    0,0,1,0, 1, 0,   0,   0,   1023, 0,  0, 0, 0);
    add(W, 0,    0,0,0,0, 2, 0,   0,   0,   1023, 0,  0, 0, 0);
    add(C, 249,  1,0,0,0, 2, 0,   249, 0,   1023, 0,  0, 0, 0);
    add(C, 1,    1,1,0,0, 3, 0,   249, 0,   1023, 0,  0, 0, 0);
    add(C, 1,    0,0,0,0, 4, 1,   249, 249, 249,  0,  0, 0, 0);
    add(C, 499,  1,0,0,0, 4, 1,   249, 249, 249,  0,  0, 0, 0);
    add(C, 1,    1,0,0,0, 1, 1,   249, 249, 249,  0,  0, 0, 0);
    add(W, 0,    0,0,0,0, 2, 1,   0,   249, 249,  0,  0, 0, 0);
    add(C, 37,   1,0,0,0, 2, 1,   37,  249, 249,  0,  0, 0, 0);
    add(C, 1,    1,0,0,1, 0, 1,   0,   249, 249,  0,  0, 0, 0);
    add(C, 3,    0,1,0,0, 0, 1,   0,   249, 249,  0,  0, 0, 0);
    add(C, 1,    0,0,1,0, 1, 0,   0,   249, 1023, 0,  0, 0, 0);
    add(C, 10,   1,0,0,0, 1, 0,   0,   249, 1023, 0,  0, 0, 0);
    add(C, 1,    1,1,0,0, 6, 0,   0,   249, 1023, 0,  0, 1, 0);
    add(C, 5,    1,1,0,0, 6, 0,   0,   249, 1023, 0,  0, 1, 0);
    add(C, 1,    0,0,1,0, 1, 0,   0,   249, 1023, 0,  0, 0, 0);
    add(W, 0,    0,0,0,0, 2, 0,   0,   249, 1023, 0,  0, 0, 0);
    add(C, 1,    0,0,1,0, 2, 0,   0,   249, 1023, 0,  0, 0, 0);
    add(C, 999,  1,0,0,0, 2, 0,   999, 249, 1023, 0,  0, 0, 0);
    add(C, 1,    1,0,0,0, 3, 0,   1000,249, 1023, 0,  0, 0, 1);
    add(C, 1,    0,0,0,0, 4, 1,   1000,1000,1000, 0,  0, 0, 1);
    add(C, 100,  1,1,0,0, 4, 1,   1000,1000,1000, 0,  0, 0, 1);
    add(C, 1,    0,0,0,1, 0, 1,   0,   1000,1000, 0,  0, 0, 1);
    add(C, 1,    0,0,1,0, 1, 0,   0,   1000,1023, 0,  0, 0, 0);
    add(W, 0,    0,0,0,0, 2, 0,   0,   1000,1023, 0,  0, 0, 0);
    add(C, 200,  1,0,0,0, 2, 0,   200, 1000,1023, 0,  0, 0, 0);
    add(C, 1,    0,1,0,0, 3, 0,   200, 1000,1023, 0,  0, 0, 0);
    add(C, 1,    0,0,0,0, 4, 1,   200, 200, 200,  0,  0, 0, 0);
    add(C, 500,  1,0,0,0, 1, 1,   200, 200, 200,  0,  0, 0, 0);
    add(W, 0,    0,0,0,0, 2, 1,   0,   200, 200,  0,  0, 0, 0);
    add(C, 300,  1,0,0,0, 2, 1,   300, 200, 200,  0,  0, 0, 0);
    add(C, 1,    0,1,0,0, 3, 1,   300, 200, 200,  0,  0, 0, 0);
    add(C, 1,    0,0,0,0, 4, 2,   300, 300, 200,  0,  0, 0, 0);
    add(C, 500,  1,0,0,0, 1, 2,   300, 300, 200,  0,  0, 0, 0);
    add(W, 0,    0,0,0,0, 2, 2,   0,   300, 200,  0,  0, 0, 0);
    add(C, 100,  1,0,0,0, 2, 2,   100, 300, 200,  0,  0, 0, 0);
    add(C, 1,    0,1,0,0, 3, 2,   100, 300, 200,  0,  0, 0, 0);
    add(C, 1,    0,0,0,0, 4, 3,   100, 100, 100,  0,  0, 0, 0);
    add(C, 500,  1,0,0,0, 1, 3,   100, 100, 100,  0,  0, 0, 0);
    add(W, 0,    0,0,0,0, 2, 3,   0,   100, 100,  0,  0, 0, 0);
    add(C, 400,  1,0,0,0, 2, 3,   400, 100, 100,  0,  0, 0, 0);
    add(C, 1,    0,1,0,0, 3, 3,   400, 100, 100,  0,  0, 0, 0);
    add(C, 1,    0,0,0,0, 5, 3,   400, 400, 100,  250,1, 0, 0);
    add(C, 5,    1,1,0,0, 5, 3,   400, 400, 100,  250,1, 0, 0);
    add(C, 1,    0,0,1,0, 1, 0,   400, 400, 1023, 250,0, 0, 0);

    for (int i = 0; i < vecs.size(); i++) begin
      row = i;
      if (vecs[i].kind == W) wait_react();
      else for (int k = 0; k < vecs[i].n; k++)
        cyc(vecs[i].t, vecs[i].r, vecs[i].s, vecs[i].a);
      check_row(vecs[i]);
    end

    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end

endmodule
